// File: rtl/seq_arith_unit.sv
// Two-stage sequential ALU with a valid/ready handshake on both sides and a stored carry flag.
// Optional build macro SEQ_ARITH_UNIT_SATURATE_EN clamps signed-overflowing results.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             cf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOP = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_ADC = 3'b100;
  localparam logic [2:0] OP_SBB = 3'b101;
  localparam logic [2:0] OP_CLC = 3'b110;
  localparam logic [2:0] OP_STC = 3'b111;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [2:0]       s1_op;
  logic             adv, accept;

  logic [WIDTH-1:0] opx, opy, nxt_res;
  logic             cin, is_arith, nxt_carry, nxt_ovf, nxt_cf;
  logic [WIDTH:0]   sum;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_vld || adv;
  assign accept   = in_valid && in_ready;

  // cf already reflects every earlier op, since all of them have left stage 1.
  always_comb begin
    opx      = s1_a;
    opy      = s1_b;
    cin      = 1'b0;
    is_arith = 1'b1;
    case (s1_op)
      OP_ADD: cin = 1'b0;
      OP_SUB: begin opy = ~s1_b; cin = 1'b1; end
      OP_ADC: cin = cf;
      OP_SBB: begin opy = ~s1_b; cin = cf; end
      OP_NEG: begin opx = ~s1_a; opy = '0; cin = 1'b1; end
      default: is_arith = 1'b0;
    endcase

    sum     = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
    nxt_res = '0;
    nxt_carry = 1'b0;
    nxt_ovf = 1'b0;
    nxt_cf  = cf;
    if (is_arith) begin
      nxt_res   = sum[WIDTH-1:0];
      nxt_carry = sum[WIDTH];
      nxt_cf    = sum[WIDTH];
      if (s1_op == OP_NEG)
        nxt_ovf = (s1_a == {1'b1, {(WIDTH-1){1'b0}}});
      else
        nxt_ovf = (opx[WIDTH-1] == opy[WIDTH-1]) && (sum[WIDTH-1] != opx[WIDTH-1]);
    end else if (s1_op == OP_CLC) begin
      nxt_cf = 1'b0;
    end else if (s1_op == OP_STC) begin
      nxt_carry = 1'b1;
      nxt_cf    = 1'b1;
    end

`ifdef SEQ_ARITH_UNIT_SATURATE_EN
    // Only NEG of the most-negative value overflows towards a positive true result with MSB set.
    if (nxt_ovf) begin
      if ((s1_op == OP_NEG) || !s1_a[WIDTH-1])
        nxt_res = {1'b0, {(WIDTH-1){1'b1}}};
      else
        nxt_res = {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      cf        <= 1'b0;
    end else begin
      if (accept) begin
        s1_vld <= 1'b1;
        s1_a   <= A;
        s1_b   <= B;
        s1_op  <= op;
      end else if (adv) begin
        s1_vld <= 1'b0;
      end

      if (adv) begin
        out_valid <= s1_vld;
        if (s1_vld) begin
          result <= nxt_res;
          carry  <= nxt_carry;
          ovf    <= nxt_ovf;
          zero   <= (nxt_res == '0);
          neg    <= nxt_res[WIDTH-1];
          cf     <= nxt_cf;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit (WIDTH=8): signed-integer reference model with a program-order carry,
// one negedge compare process, plus directed vectors.
module tb_seq_arith_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B;
  logic [2:0] op;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] result;
  logic       carry, ovf, zero, neg, cf;

  seq_arith_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero), .neg(neg), .cf(cf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       c, o, z, n, cf_after;
  } exp_t;

  exp_t q[$];
  logic mcf;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] o, input int a, input int b, input logic cin);
    exp_t e;
    int   s, tv, sa, sb;
    bit   ar;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    s = 0; tv = 0; ar = 1;
    case (o)
      3'd0: begin s = a + b;             tv = sa + sb;           end
      3'd1: begin s = a + (255 - b) + 1; tv = sa - sb;           end
      3'd4: begin s = a + b + cin;       tv = sa + sb + cin;     end
      3'd5: begin s = a + (255 - b) + cin; tv = sa - sb - 1 + cin; end
      3'd3: begin s = 256 - a;           tv = -sa;               end
      default: ar = 0;
    endcase
    e.res = s[7:0];
    e.c   = ar ? s[8] : (o == 3'd7);
    e.o   = ar && (tv > 127 || tv < -128);
`ifdef SEQ_ARITH_UNIT_SATURATE_EN
    if (e.o) e.res = (tv > 0) ? 8'h7F : 8'h80;
`endif
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    e.cf_after = ar ? e.c : (o == 3'd6) ? 1'b0 : (o == 3'd7) ? 1'b1 : cin;
    return e;
  endfunction

  // Compare process: outputs checked every cycle they are valid; stalls must hold them.
  logic       stall = 1'b0;
  logic [7:0] p_res;
  logic       p_c, p_o, p_z, p_n;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcf   = 1'b0;
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_result", result, p_res);
        chk("stall_flags", {carry, ovf, zero, neg}, {p_c, p_o, p_z, p_n});
      end
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          chk("result", result, q[0].res);
          chk("flags_cozn", {carry, ovf, zero, neg}, {q[0].c, q[0].o, q[0].z, q[0].n});
          chk("cf", cf, q[0].cf_after);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(op, int'(A), int'(B), mcf);
        mcf = e.cf_after;
        q.push_back(e);
      end
      stall = out_valid && !out_ready;
      p_res = result; p_c = carry; p_o = ovf; p_z = zero; p_n = neg;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the op has been accepted.
  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic ok;
    int   guard;
    guard = 0;
    in_valid = 1'b1; op = o; A = a; B = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 60);
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    exp_t m;
    bit   rand_done;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
    cycles(2);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", zero, 1);
    chk("rst_cf", cf, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Pin the model against hand-computed values.
    m = model(3'd0, 'h7F, 'h01, 1'b0);
`ifdef SEQ_ARITH_UNIT_SATURATE_EN
    chk("pin_add_res", m.res, 8'h7F);
    chk("pin_add_n", m.n, 0);
`else
    chk("pin_add_res", m.res, 8'h80);
    chk("pin_add_n", m.n, 1);
`endif
    chk("pin_add_oc", {m.o, m.c}, 2'b10);
    m = model(3'd1, 'h05, 'h05, 1'b0);
    chk("pin_sub", {m.res, m.z, m.c, m.cf_after}, {8'h00, 3'b111});
    m = model(3'd5, 'h00, 'h01, 1'b1);
    chk("pin_sbb", {m.res, m.c, m.n}, {8'hFF, 2'b01});
    m = model(3'd3, 'h80, 'h00, 1'b0);
`ifdef SEQ_ARITH_UNIT_SATURATE_EN
    chk("pin_neg_min", {m.res, m.o}, {8'h7F, 1'b1});
`else
    chk("pin_neg_min", {m.res, m.o}, {8'h80, 1'b1});
`endif
    m = model(3'd3, 'h00, 'h00, 1'b0);
    chk("pin_neg_zero", {m.res, m.c}, {8'h00, 1'b1});
    m = model(3'd4, 'h00, 'h00, 1'b1);
    chk("pin_adc", m.res, 8'h01);

    // Directed vectors, back-to-back with out_ready high.
    send(3'd0, 8'h7F, 8'h01);
    send(3'd1, 8'h05, 8'h05);
    send(3'd5, 8'h00, 8'h01);
    send(3'd0, 8'hFF, 8'h01);
    send(3'd4, 8'h00, 8'h00);
    send(3'd3, 8'h80, 8'h00);
    send(3'd3, 8'h00, 8'h00);
    send(3'd7, 8'h12, 8'h34);
    send(3'd2, 8'h55, 8'hAA);
    send(3'd4, 8'h10, 8'h20);
    send(3'd6, 8'h00, 8'h00);
    send(3'd4, 8'h10, 8'h20);
    cycles(4);
    chk("directed_drained", q.size(), 0);

    // Backpressure: two ops fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(3'd0, 8'h01, 8'h02);
    send(3'd1, 8'h10, 8'h03);
    fork
      send(3'd4, 8'h40, 8'h40);
      begin
        repeat (3) begin @(negedge clk); chk("bp_in_ready_low", in_ready, 0); end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    cycles(4);
    chk("bp_drained", q.size(), 0);

    // Randomised ops under random backpressure.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    cycles(4);
    chk("rand_drained", q.size(), 0);

    // Reset with both stages full and cf set: nothing in flight may emerge.
    out_ready = 1'b0;
    send(3'd7, 8'h00, 8'h00);
    send(3'd0, 8'hFF, 8'h01);
    cycles(1);
    chk("pre_rst_full", {out_valid, in_ready, cf}, 3'b101);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cf", cf, 0);
    chk("mid_rst_zero", zero, 1);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    cycles(5);
    chk("no_stale", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
